needs_decay: RTL and testbench
==============================

// Module: needs_decay
// PURPOSE
//  Pet-needs engine for the tamagotchi. Re-arms the 1 s temporizador (init/done)
//  and consumes its completion to produce a one-second tick. Each tick ages the
//  hunger, happiness and energy levels at per-need rates. Applies user events
//  (feed, play, sleep) and flags an alarm to the display/FSM when any need is empty.
// PARAMETERS
//  LVL_W       3   width of each need level
//  LVL_MAX     7   full level; also the reset value
//  DIV_W       4   width of the per-need tick dividers
//  HUNGER_DIV  5   ticks per hunger decrement
//  JOY_DIV     7   ticks per happiness decrement
//  ENERGY_DIV  10  ticks per energy decrement while awake
//  FEED_INC    3   hunger gain per feed_evt
//  PLAY_INC    2   happiness gain per play_evt
// PORTS
//  clk         in   1      system clock
//  rst         in   1      synchronous reset, active-high
//  enable      in   1      1 = pet alive/running, 0 = time frozen
//  timer_done  in   1      done from temporizador
//  timer_init  out  1      init to temporizador (1-cycle pulse)
//  feed_evt    in   1      1-cycle pulse: feed
//  play_evt    in   1      1-cycle pulse: play
//  sleeping    in   1      level: pet asleep
//  hunger      out  LVL_W  satiety level (LVL_MAX = full)
//  happiness   out  LVL_W  happiness level
//  energy      out  LVL_W  energy level
//  tick        out  1      1-cycle pulse per completed timer period
//  alarm       out  1      registered: any level == 0
// BEHAVIOUR
//  Reset (sync, rst=1 at posedge): state=IDLE, timer_init=0, tick=0, alarm=0,
//   all levels=LVL_MAX, all dividers=0. rst wins over every other input.
//  FSM: IDLE -> ARM (when enable=1).
//   ARM: timer_init=1 for exactly one cycle -> WAIT_CLR.
//   WAIT_CLR: wait for timer_done==0 (timer acknowledged init) -> WAIT_DONE.
//   WAIT_DONE: on timer_done==1 -> TICK.
//   TICK: tick=1 for one cycle, levels update -> ARM if enable, else IDLE.
//  enable=0 in ARM/WAIT_CLR/WAIT_DONE -> IDLE next cycle; partial period discarded.
//  Timer has no reset: after rst mid-count, the stale period may complete early.
//   Only the first tick after reset may be short; never a double tick.
//  Tick period = timer period + 3 cycles of handshake overhead.
//  Divider k counts ticks 0..DIV_k-1; on wrap the need is decremented.
//   Dividers advance only on tick.
//  sleeping=1: energy +1 per tick (sat LVL_MAX). Energy divider held at 0.
//   feed_evt and play_evt are ignored while sleeping.
//  feed_evt: hunger += FEED_INC. play_evt: happiness += PLAY_INC, energy -= 1.
//  Arithmetic: unsigned, saturate at 0 and LVL_MAX. Never wrap.
//   Same cycle as tick: new = sat(sat0(old - decay) + gain).
//  Events are accepted in any state, including IDLE. Levels and dividers hold
//   when there is no tick and no event.
//  alarm updates one cycle after a level changes: alarm <= (any next level == 0).
//  feed_evt and play_evt in the same cycle: both are applied.
// TESTING
//  1 Reset, enable=1, timer model 20 cycles -> init pulses 1 cycle; tick every 23 cycles.
//  2 5 ticks, no events -> hunger 7->6; happiness 7; energy 7.
//  3 Force hunger=1, feed_evt on the same cycle as a hunger-decrement tick -> hunger=3.
//  4 Drive all levels to 0 -> alarm=1 next cycle, levels stay 0.
//    Then feed -> hunger=3 and alarm stays 1 (happiness and energy still 0).
//  5 sleeping=1, energy=4, 3 ticks -> energy=7, 5th tick still 7; play_evt ignored.
//  6 rst mid WAIT_DONE with timer counting -> outputs at reset values;
//    at most one early tick, then a steady 23-cycle period.
//    enable=0 mid-wait -> IDLE and no tick.

Source files
------------

// File: rtl/needs_decay.sv
// needs_decay: paces a one-second tick from the external temporizador and ages
// the pet's hunger, happiness and energy levels, applying user feed/play events.
//
// state       | meaning
// S_IDLE      | time frozen, waiting for enable
// S_ARM       | timer_init pulse, restarts the temporizador
// S_WAIT_CLR  | waiting for the timer to drop done (init acknowledged)
// S_WAIT_DONE | timing the period, waiting for done
// S_TICK      | tick pulse, needs age on this cycle

module needs_decay #(
  parameter int LVL_W      = 3,
  parameter int LVL_MAX    = 7,
  parameter int DIV_W      = 4,
  parameter int HUNGER_DIV = 5,
  parameter int JOY_DIV    = 7,
  parameter int ENERGY_DIV = 10,
  parameter int FEED_INC   = 3,
  parameter int PLAY_INC   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             timer_done,
  output logic             timer_init,
  input  logic             feed_evt,
  input  logic             play_evt,
  input  logic             sleeping,
  output logic [LVL_W-1:0] hunger,
  output logic [LVL_W-1:0] happiness,
  output logic [LVL_W-1:0] energy,
  output logic             tick,
  output logic             alarm
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_WAIT_CLR,
    S_WAIT_DONE,
    S_TICK
  } state_t;

  localparam logic [LVL_W-1:0] MAX_L  = LVL_W'(LVL_MAX);
  localparam logic [LVL_W+1:0] MAX_W  = (LVL_W+2)'(LVL_MAX);
  localparam logic [LVL_W-1:0] FEED_L = LVL_W'(FEED_INC);
  localparam logic [LVL_W-1:0] PLAY_L = LVL_W'(PLAY_INC);
  localparam logic [LVL_W-1:0] ONE_L  = LVL_W'(1);
  localparam logic [DIV_W-1:0] H_LAST = DIV_W'(HUNGER_DIV - 1);
  localparam logic [DIV_W-1:0] J_LAST = DIV_W'(JOY_DIV - 1);
  localparam logic [DIV_W-1:0] E_LAST = DIV_W'(ENERGY_DIV - 1);

  state_t           state_q, state_d;
  logic             timer_init_q, timer_init_d;
  logic             tick_q, tick_d;
  logic             alarm_q, alarm_d;
  logic [LVL_W-1:0] hunger_q, hunger_d;
  logic [LVL_W-1:0] happiness_q, happiness_d;
  logic [LVL_W-1:0] energy_q, energy_d;
  logic [DIV_W-1:0] h_div_q, h_div_d;
  logic [DIV_W-1:0] j_div_q, j_div_d;
  logic [DIV_W-1:0] e_div_q, e_div_d;
  logic             h_wrap, j_wrap, e_wrap;
  logic             feed_ok, play_ok;
  logic [1:0]       e_dec;

  // Decay is removed first (clamped at 0), then the gain is added (clamped at full).
  function automatic logic [LVL_W-1:0] sat_upd(input logic [LVL_W-1:0] old,
                                                input logic [1:0]       dec,
                                                input logic [LVL_W-1:0] inc);
    logic [LVL_W+1:0] wide_old;
    logic [LVL_W+1:0] wide_dec;
    logic [LVL_W+1:0] base;
    logic [LVL_W+1:0] sum;
    wide_old = {2'b00, old};
    wide_dec = {{LVL_W{1'b0}}, dec};
    base     = (wide_old > wide_dec) ? (wide_old - wide_dec) : '0;
    sum      = base + {2'b00, inc};
    return (sum > MAX_W) ? MAX_L : sum[LVL_W-1:0];
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (enable) state_d = S_ARM;
      S_ARM:       state_d = enable ? S_WAIT_CLR : S_IDLE;
      S_WAIT_CLR: begin
        if (!enable)          state_d = S_IDLE;
        else if (!timer_done) state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (!enable)         state_d = S_IDLE;
        else if (timer_done) state_d = S_TICK;
      end
      S_TICK:      state_d = enable ? S_ARM : S_IDLE;
      default:     state_d = S_IDLE;
    endcase
    timer_init_d = (state_d == S_ARM);
    tick_d       = (state_d == S_TICK);
  end

  always_comb begin
    feed_ok = feed_evt & ~sleeping;
    play_ok = play_evt & ~sleeping;

    h_div_d = h_div_q;
    h_wrap  = 1'b0;
    if (tick_q) begin
      if (h_div_q == H_LAST) begin
        h_div_d = '0;
        h_wrap  = 1'b1;
      end else begin
        h_div_d = h_div_q + 1'b1;
      end
    end

    j_div_d = j_div_q;
    j_wrap  = 1'b0;
    if (tick_q) begin
      if (j_div_q == J_LAST) begin
        j_div_d = '0;
        j_wrap  = 1'b1;
      end else begin
        j_div_d = j_div_q + 1'b1;
      end
    end

    // A sleeping pet recovers instead of tiring, so its energy divider restarts.
    e_div_d = e_div_q;
    e_wrap  = 1'b0;
    if (sleeping) begin
      e_div_d = '0;
    end else if (tick_q) begin
      if (e_div_q == E_LAST) begin
        e_div_d = '0;
        e_wrap  = 1'b1;
      end else begin
        e_div_d = e_div_q + 1'b1;
      end
    end

    e_dec       = {1'b0, e_wrap} + {1'b0, play_ok};
    hunger_d    = sat_upd(hunger_q, {1'b0, h_wrap}, feed_ok ? FEED_L : '0);
    happiness_d = sat_upd(happiness_q, {1'b0, j_wrap}, play_ok ? PLAY_L : '0);
    energy_d    = sat_upd(energy_q, e_dec, (tick_q & sleeping) ? ONE_L : '0);
    alarm_d     = (hunger_d == '0) | (happiness_d == '0) | (energy_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      timer_init_q <= 1'b0;
      tick_q       <= 1'b0;
      alarm_q      <= 1'b0;
      hunger_q     <= MAX_L;
      happiness_q  <= MAX_L;
      energy_q     <= MAX_L;
      h_div_q      <= '0;
      j_div_q      <= '0;
      e_div_q      <= '0;
    end else begin
      state_q      <= state_d;
      timer_init_q <= timer_init_d;
      tick_q       <= tick_d;
      alarm_q      <= alarm_d;
      hunger_q     <= hunger_d;
      happiness_q  <= happiness_d;
      energy_q     <= energy_d;
      h_div_q      <= h_div_d;
      j_div_q      <= j_div_d;
      e_div_q      <= e_div_d;
    end
  end

  assign timer_init = timer_init_q;
  assign tick       = tick_q;
  assign alarm      = alarm_q;
  assign hunger     = hunger_q;
  assign happiness  = happiness_q;
  assign energy     = energy_q;

endmodule

// File: tb/tb_needs_decay.sv
// tb_needs_decay: directed bench for needs_decay with a behavioural temporizador
// whose period can be changed between arms.

module tb_needs_decay;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       timer_done = 1'b1;
  logic       timer_init;
  logic       feed_evt;
  logic       play_evt;
  logic       sleeping;
  logic [2:0] hunger;
  logic [2:0] happiness;
  logic [2:0] energy;
  logic       tick;
  logic       alarm;

  int tmr_per = 20;
  int tmr_cnt = 0;
  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;
  int n_tick = 0;
  bit tmo = 1'b0;

  needs_decay dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .timer_done (timer_done),
    .timer_init (timer_init),
    .feed_evt   (feed_evt),
    .play_evt   (play_evt),
    .sleeping   (sleeping),
    .hunger     (hunger),
    .happiness  (happiness),
    .energy     (energy),
    .tick       (tick),
    .alarm      (alarm)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Temporizador: init restarts the count; done rises tmr_per cycles later and holds.
  always @(posedge clk) begin
    if (timer_init) begin
      tmr_cnt    <= tmr_per;
      timer_done <= 1'b0;
    end else if (tmr_cnt > 1) begin
      tmr_cnt <= tmr_cnt - 1;
    end else if (tmr_cnt == 1) begin
      tmr_cnt    <= 0;
      timer_done <= 1'b1;
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_tick(output int at);
    at = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (tick) begin
        n_tick++;
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      tmo = 1'b1;
      chk("tick_timeout", int'(tick), 1);
    end
  endtask

  task automatic run_to(input int k);
    int t;
    while (n_tick < k && !tmo) wait_tick(t);
  endtask

  task automatic chk_lvls(input string tag, input int h, input int j, input int e);
    chk({tag, "_hunger"}, int'(hunger), h);
    chk({tag, "_happiness"}, int'(happiness), j);
    chk({tag, "_energy"}, int'(energy), e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int t_tick [6];
    int t1, t2, rel, n_tk, n_in;
    bit seen;

    // Reset wins over enable and events.
    rst = 1'b1; enable = 1'b1; feed_evt = 1'b1; play_evt = 1'b1; sleeping = 1'b0;
    repeat (3) @(negedge clk);
    chk_lvls("rst", 7, 7, 7);
    chk("rst_alarm", int'(alarm), 0);
    chk("rst_tick", int'(tick), 0);
    chk("rst_init", int'(timer_init), 0);
    rst = 1'b0; feed_evt = 1'b0; play_evt = 1'b0;

    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (timer_init) begin
        seen = 1'b1;
        break;
      end
    end
    chk("init_seen", int'(seen), 1);
    @(negedge clk);
    chk("init_width", int'(timer_init), 0);

    for (int i = 1; i <= 5; i++) wait_tick(t_tick[i]);
    for (int i = 2; i <= 5; i++) chk($sformatf("period_%0d", i), t_tick[i] - t_tick[i-1], 23);
    @(negedge clk);
    chk("tick_width", int'(tick), 0);
    chk_lvls("t5", 6, 7, 7);

    run_to(30);
    @(negedge clk);
    chk_lvls("t30", 1, 3, 4);

    // Feed lands on the same cycle as a hunger-decrement tick.
    run_to(34);
    wait_tick(t1);
    feed_evt = 1'b1;
    @(negedge clk);
    feed_evt = 1'b0;
    chk_lvls("t35_feed", 3, 2, 4);
    chk("t35_alarm", int'(alarm), 0);

    play_evt = 1'b1;
    repeat (3) @(negedge clk);
    chk("play3_energy", int'(energy), 1);
    chk("play3_alarm", int'(alarm), 0);
    @(negedge clk);
    play_evt = 1'b0;
    chk("play4_energy", int'(energy), 0);
    chk("play4_happiness", int'(happiness), 7);
    chk("play4_alarm", int'(alarm), 1);

    tmr_per = 2;
    run_to(50);
    @(negedge clk);
    chk("t50_hunger", int'(hunger), 0);
    run_to(84);
    @(negedge clk);
    chk_lvls("t84", 0, 0, 0);
    chk("t84_alarm", int'(alarm), 1);
    run_to(85);
    @(negedge clk);
    chk_lvls("t85", 0, 0, 0);

    feed_evt = 1'b1;
    @(negedge clk);
    feed_evt = 1'b0;
    chk("feed0_hunger", int'(hunger), 3);
    chk("feed0_alarm", int'(alarm), 1);

    sleeping = 1'b1;
    run_to(89);
    @(negedge clk);
    chk("sleep4_energy", int'(energy), 4);
    feed_evt = 1'b1; play_evt = 1'b1;
    @(negedge clk);
    feed_evt = 1'b0; play_evt = 1'b0;
    chk_lvls("sleep_ign", 3, 0, 4);
    run_to(92);
    @(negedge clk);
    chk("sleep7_energy", int'(energy), 7);
    run_to(94);
    @(negedge clk);
    chk("sleep9_energy", int'(energy), 7);

    // Reset in the middle of a timed period, with a feed that must be lost.
    sleeping = 1'b0;
    tmr_per = 20;
    run_to(95);
    repeat (10) @(negedge clk);
    rst = 1'b1; feed_evt = 1'b1;
    @(negedge clk);
    chk_lvls("mid_rst", 7, 7, 7);
    chk("mid_rst_alarm", int'(alarm), 0);
    chk("mid_rst_tick", int'(tick), 0);
    chk("mid_rst_init", int'(timer_init), 0);
    rst = 1'b0; feed_evt = 1'b0;
    rel = cyc;
    wait_tick(t1);
    chk("first_tick_le23", int'(t1 >= 0 && (t1 - rel) <= 23), 1);
    wait_tick(t2);
    chk("post_rst_period", t2 - t1, 23);

    // Freeze mid-wait: no init, no tick, levels hold, events still accepted.
    repeat (10) @(negedge clk);
    enable = 1'b0;
    n_tk = 0; n_in = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tick) n_tk++;
      if (timer_init) n_in++;
    end
    chk("frozen_ticks", n_tk, 0);
    chk("frozen_inits", n_in, 0);
    chk_lvls("frozen", 7, 7, 7);
    feed_evt = 1'b1; play_evt = 1'b1;
    @(negedge clk);
    feed_evt = 1'b0; play_evt = 1'b0;
    chk_lvls("idle_evts", 7, 7, 6);

    enable = 1'b1;
    rel = cyc;
    wait_tick(t1);
    chk("resume_latency", t1 - rel, 23);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
